sap_control_sequencer: RTL and testbench

- Fetch/decode/execute controller that sits directly upstream of the adder/accumulator datapath.
- Reads instruction bytes from an asynchronous program ROM, drives the shared 8-bit bus, and generates the datapath control strobes: active-low A/B loads, accumulator output enable, ALU output enable and subtract.
- Latches the ALU carry and zero flags for conditional jumps.

---
 rtl/sap_control_sequencer.sv | 144 ++++++++++++++
 tb/tb_sap_control_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// Fetch/decode/execute sequencer for the SAP adder/accumulator datapath.
// Moore control strobes are decoded from (state, IR); PC, MAR, IR and flags are registered.
module sap_control_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              nLa,
  output logic              nLb,
  output logic              Ea,
  output logic              Eu,
  output logic              sub,
  input  logic              cf_in,
  input  logic              zf_in,
  output logic              out_strobe,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int OP_W = DATA_W - ADDR_W;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_ir;
  logic                r_flag_c;
  logic                r_flag_z;
  logic [OP_W-1:0]     w_op;
  logic [ADDR_W-1:0]   w_n;

  assign w_op     = r_ir[DATA_W-1:ADDR_W];
  assign w_n      = r_ir[ADDR_W-1:0];
  assign mem_addr = r_mar;
  assign pc       = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_mar    <= '0;
      r_ir     <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_T0: r_mar <= r_pc;
        S_T1: begin
          r_ir <= mem_data;
          r_pc <= r_pc + ADDR_W'(1);
        end
        // decode: operand fetch address or jump target
        S_T2: begin
          if (w_op == OP_LDA || w_op == OP_ADD || w_op == OP_SUB) r_mar <= w_n;
          if (w_op == OP_JMP ||
              (w_op == OP_JC && r_flag_c) ||
              (w_op == OP_JZ && r_flag_z)) r_pc <= w_n;
        end
        S_T4: begin
          r_flag_c <= cf_in;
          r_flag_z <= zf_in;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    nLa        = 1'b1;
    nLb        = 1'b1;
    Ea         = 1'b0;
    Eu         = 1'b0;
    sub        = 1'b0;
    bus_drive  = 1'b0;
    bus_out    = '0;
    out_strobe = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2: begin
        w_next = S_T0;
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB: w_next = S_T3;
          OP_LDI: begin
            bus_drive = 1'b1;
            bus_out   = {{OP_W{1'b0}}, w_n};
            nLa       = 1'b0;
          end
          OP_OUT: begin
            Ea         = 1'b1;
            out_strobe = 1'b1;
          end
          OP_HLT:  w_next = S_HALT;
          default: ;
        endcase
      end
      // memory operand onto the bus: LDA finishes here, ADD/SUB load B first
      S_T3: begin
        bus_drive = 1'b1;
        bus_out   = mem_data;
        if (w_op == OP_LDA) begin
          nLa    = 1'b0;
          w_next = S_T0;
        end else begin
          nLb    = 1'b0;
          w_next = S_T4;
        end
      end
      S_T4: begin
        Eu     = 1'b1;
        sub    = (w_op == OP_SUB);
        nLa    = 1'b0;
        w_next = S_T0;
      end
      S_HALT:  halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed testbench for sap_control_sequencer with a behavioural async ROM.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] bus_out;
  logic       bus_drive, nLa, nLb, Ea, Eu, sub, out_strobe, halted;
  logic       cf_in = 1'b0;
  logic       zf_in = 1'b0;
  logic [3:0] pc;
  logic [7:0] rom [16];
  logic [7:0] ctl;

  int checks = 0;
  int failures = 0;

  // control word: {bus_drive, nLa, nLb, Ea, Eu, sub, out_strobe, halted}
  localparam logic [7:0] C_IDLE = 8'h60;
  localparam logic [7:0] C_LDA  = 8'hA0;
  localparam logic [7:0] C_LDB  = 8'hC0;
  localparam logic [7:0] C_OUT  = 8'h72;
  localparam logic [7:0] C_ADD  = 8'h28;
  localparam logic [7:0] C_SUB  = 8'h2C;
  localparam logic [7:0] C_HALT = 8'h61;

  assign mem_data = rom[mem_addr];
  assign ctl = {bus_drive, nLa, nLb, Ea, Eu, sub, out_strobe, halted};

  sap_control_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
    .bus_out(bus_out), .bus_drive(bus_drive), .nLa(nLa), .nLb(nLb), .Ea(Ea), .Eu(Eu),
    .sub(sub), .cf_in(cf_in), .zf_in(zf_in), .out_strobe(out_strobe), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((int'(bus_drive) + int'(Ea) + int'(Eu)) > 1 || (!nLa && !nLb)) begin
        failures++;
        $display("FAIL invariant t=%0t ctl=%h required one bus source and not both loads", $time, ctl);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic apply_reset();
    start = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // leaves the DUT in T0 of the first instruction
  task automatic begin_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom(8'hF0);
    apply_reset();
    checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL reset_ctl got=%h exp=%h", ctl, C_IDLE); end
    checks++; if (bus_out !== 8'h00) begin failures++; $display("FAIL reset_bus got=%h exp=00", bus_out); end
    checks++; if ({pc, mem_addr} !== 8'h00) begin failures++; $display("FAIL reset_pc_mar got=%h exp=00", {pc, mem_addr}); end
    tick(3);
    checks++; if (pc !== 4'd0 || ctl !== C_IDLE) begin failures++; $display("FAIL idle_wait pc=%h ctl=%h exp pc=0 ctl=%h", pc, ctl, C_IDLE); end
  endtask

  task automatic test_ldi_out_hlt();
    fill_rom(8'h00);
    rom[0] = 8'h4A; rom[1] = 8'hE0; rom[2] = 8'hF0;
    apply_reset();
    begin_run();
    tick(1);
    checks++; if (mem_addr !== 4'd0) begin failures++; $display("FAIL t1_mar got=%h exp=0", mem_addr); end
    tick(1);
    checks++; if (ctl !== C_LDA || bus_out !== 8'h0A) begin failures++; $display("FAIL ldi_t2 ctl=%h bus=%h exp ctl=%h bus=0a", ctl, bus_out, C_LDA); end
    tick(2);
    checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL out_t1 got=%h exp=%h", ctl, C_IDLE); end
    tick(1);
    checks++; if (ctl !== C_OUT || bus_out !== 8'h00) begin failures++; $display("FAIL out_t2 ctl=%h bus=%h exp ctl=%h bus=00", ctl, bus_out, C_OUT); end
    tick(1);
    checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL out_pulse_end got=%h exp=%h", ctl, C_IDLE); end
    tick(2);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hlt_t2 halted=%b exp=0", halted); end
    tick(1);
    checks++; if (ctl !== C_HALT || pc !== 4'd3) begin failures++; $display("FAIL halt ctl=%h pc=%h exp ctl=%h pc=3", ctl, pc, C_HALT); end
    start = 1'b1;
    tick(4);
    start = 1'b0;
    checks++; if (ctl !== C_HALT || pc !== 4'd3) begin failures++; $display("FAIL halt_sticky ctl=%h pc=%h exp ctl=%h pc=3", ctl, pc, C_HALT); end
  endtask

  task automatic test_add();
    fill_rom(8'hF0);
    rom[0] = 8'h1E; rom[1] = 8'h2F; rom[2] = 8'h7C; rom[3] = 8'h6C;
    rom[14] = 8'h05; rom[15] = 8'h03;
    cf_in = 1'b0; zf_in = 1'b0;
    apply_reset();
    begin_run();
    tick(3);
    checks++; if (ctl !== C_LDA || bus_out !== 8'h05) begin failures++; $display("FAIL lda_t3 ctl=%h bus=%h exp ctl=%h bus=05", ctl, bus_out, C_LDA); end
    tick(4);
    checks++; if (ctl !== C_LDB || bus_out !== 8'h03) begin failures++; $display("FAIL add_t3 ctl=%h bus=%h exp ctl=%h bus=03", ctl, bus_out, C_LDB); end
    tick(1);
    checks++; if (ctl !== C_ADD || bus_out !== 8'h00) begin failures++; $display("FAIL add_t4 ctl=%h bus=%h exp ctl=%h bus=00", ctl, bus_out, C_ADD); end
    tick(1);
    checks++; if (pc !== 4'd2) begin failures++; $display("FAIL add_pc got=%h exp=2", pc); end
    tick(3);
    checks++; if (pc !== 4'd3) begin failures++; $display("FAIL jz_flag0 pc=%h exp=3", pc); end
    tick(3);
    checks++; if (pc !== 4'd4) begin failures++; $display("FAIL jc_flag0 pc=%h exp=4", pc); end
  endtask

  task automatic test_sub_jumps();
    fill_rom(8'hF0);
    rom[0] = 8'h3B; rom[1] = 8'h7C; rom[11] = 8'h01; rom[12] = 8'h6E;
    rom[14] = 8'h3B; rom[15] = 8'h6A;
    apply_reset();
    cf_in = 1'b1; zf_in = 1'b1;
    begin_run();
    tick(4);
    checks++; if (ctl !== C_SUB) begin failures++; $display("FAIL sub_t4 got=%h exp=%h", ctl, C_SUB); end
    tick(4);
    checks++; if (pc !== 4'd12) begin failures++; $display("FAIL jz_taken pc=%h exp=c", pc); end
    tick(3);
    checks++; if (pc !== 4'd14) begin failures++; $display("FAIL jc_taken pc=%h exp=e", pc); end
    cf_in = 1'b0; zf_in = 1'b0;
    tick(4);
    checks++; if (ctl !== C_SUB) begin failures++; $display("FAIL sub2_t4 got=%h exp=%h", ctl, C_SUB); end
    tick(4);
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL jc_not_taken_wrap pc=%h exp=0", pc); end
  endtask

  task automatic test_nop_wrap();
    logic [3:0] exp_pc;
    fill_rom(8'h00);
    apply_reset();
    begin_run();
    exp_pc = 4'd0;
    for (int i = 0; i < 17; i++) begin
      for (int c = 0; c < 3; c++) begin
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL nop_strobe i=%0d c=%0d got=%h exp=%h", i, c, ctl, C_IDLE); end
        tick(1);
      end
      exp_pc = exp_pc + 4'd1;
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL nop_pc i=%0d got=%h exp=%h", i, pc, exp_pc); end
    end
  endtask

  task automatic test_reset_mid();
    fill_rom(8'hF0);
    rom[0] = 8'h1E; rom[1] = 8'h2F; rom[14] = 8'h05; rom[15] = 8'h03;
    apply_reset();
    begin_run();
    tick(8);
    checks++; if (ctl !== C_ADD) begin failures++; $display("FAIL pre_reset_t4 got=%h exp=%h", ctl, C_ADD); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ctl !== C_IDLE || bus_out !== 8'h00 || pc !== 4'd0 || mem_addr !== 4'd0) begin
      failures++; $display("FAIL async_reset ctl=%h bus=%h pc=%h mar=%h exp ctl=%h zeros", ctl, bus_out, pc, mem_addr, C_IDLE);
    end
    tick(1);
    rst_n = 1'b1;
    tick(4);
    checks++; if (ctl !== C_IDLE || pc !== 4'd0 || mem_addr !== 4'd0) begin failures++; $display("FAIL idle_after_reset ctl=%h pc=%h mar=%h exp idle", ctl, pc, mem_addr); end
    begin_run();
    tick(3);
    checks++; if (ctl !== C_LDA || bus_out !== 8'h05) begin failures++; $display("FAIL restart_lda ctl=%h bus=%h exp ctl=%h bus=05", ctl, bus_out, C_LDA); end
  endtask

  initial begin
    fill_rom(8'h00);
    test_reset();
    test_ldi_out_hlt();
    test_add();
    test_sub_jumps();
    test_nop_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
